// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the baud divisor table,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int BAUD_W = 14;

  localparam logic [BAUD_W-1:0] BAUD_DIV_0 = 14'd10416;
  localparam logic [BAUD_W-1:0] BAUD_DIV_1 = 14'd5208;
  localparam logic [BAUD_W-1:0] BAUD_DIV_2 = 14'd2604;
  localparam logic [BAUD_W-1:0] BAUD_DIV_3 = 14'd1736;
  localparam logic [BAUD_W-1:0] BAUD_DIV_4 = 14'd868;
  localparam logic [BAUD_W-1:0] BAUD_DIV_5 = 14'd434;
  localparam logic [BAUD_W-1:0] BAUD_DIV_6 = 14'd217;
  localparam logic [BAUD_W-1:0] BAUD_DIV_7 = 14'd108;

  function automatic logic [BAUD_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    baud_div = BAUD_DIV_0;
      3'd1:    baud_div = BAUD_DIV_1;
      3'd2:    baud_div = BAUD_DIV_2;
      3'd3:    baud_div = BAUD_DIV_3;
      3'd4:    baud_div = BAUD_DIV_4;
      3'd5:    baud_div = BAUD_DIV_5;
      3'd6:    baud_div = BAUD_DIV_6;
      default: baud_div = BAUD_DIV_7;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div-1 while run is high and emits tick on the
// last cycle of each bit; held at zero whenever run is low.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [BAUD_W-1:0] div,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt;

  assign tick = run && (cnt == div - 14'd1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 14'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, STOP_BITS stop bits.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, tx_ready follows uart_en
// START  | start bit, line low for one bit period
// DATA   | 8 data bits from shift[0], LSB first
// PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_BITS bit periods, tx_done on exit
module uart_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       uart_en,
  input  logic [2:0] baud_tx_sel,
  input  logic       tx_valid,
  input  logic [7:0] tx_dat,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       TX
);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  uart_state_t       state;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic [2:0]        sel_lat;
  logic              stop_cnt;
  logic              run;
  logic              tick;
  logic [BAUD_W-1:0] div;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign tx_ready = (state == IDLE) && uart_en;
  assign tx_busy  = (state != IDLE);
  assign run      = tx_busy && uart_en;
  assign div      = baud_div(sel_lat);

  uart_baud_gen u_baud_gen (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .div    (div),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      sel_lat  <= 3'd0;
      stop_cnt <= 1'b0;
      tx_done  <= 1'b0;
      TX       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      // Losing the enable mid-frame abandons the frame without a done pulse.
      if (tx_busy && !uart_en) begin
        state    <= IDLE;
        TX       <= 1'b1;
        bit_cnt  <= 3'd0;
        stop_cnt <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid && uart_en) begin
              shift    <= tx_dat;
              sel_lat  <= baud_tx_sel;
              bit_cnt  <= 3'd0;
              stop_cnt <= 1'b0;
              state    <= START;
              TX       <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par      <= ^tx_dat;
`endif
            end
          end
          START: begin
            if (tick) begin
              state <= DATA;
              TX    <= shift[0];
            end
          end
          DATA: begin
            if (tick) begin
              shift <= {1'b0, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                state   <= PARITY;
                TX      <= par;
`else
                state   <= STOP;
                TX      <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                TX      <= shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (tick) begin
              state <= STOP;
              TX    <= 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick) begin
              if (stop_cnt == STOP_LAST) begin
                state    <= IDLE;
                stop_cnt <= 1'b0;
                tx_done  <= 1'b1;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            TX    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with 1 stop bit, one with 2,
// sharing the data inputs but enabled separately.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       en1, en2;
  logic [2:0] baud_tx_sel;
  logic       tx_valid;
  logic [7:0] tx_dat;
  logic       rdy1, busy1, done1, tx1;
  logic       rdy2, busy2, done2, tx2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx #(.STOP_BITS(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .uart_en(en1), .baud_tx_sel(baud_tx_sel),
    .tx_valid(tx_valid), .tx_dat(tx_dat), .tx_ready(rdy1), .tx_busy(busy1),
    .tx_done(done1), .TX(tx1)
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .clock(clock), .resetn(resetn), .uart_en(en2), .baud_tx_sel(baud_tx_sel),
    .tx_valid(tx_valid), .tx_dat(tx_dat), .tx_ready(rdy2), .tx_busy(busy2),
    .tx_done(done2), .TX(tx2)
  );

  typedef struct {
    logic [7:0] dat;
    logic [2:0] sel;
    int         sb;
    int         n;
    int         len;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic exp_line(input int i, input logic [7:0] d);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (PAR == 1 && i == 9) return ^d;
    return 1'b1;
  endfunction

  // Presents a byte and consumes the accepting edge; returns in START cycle 0.
  task automatic start_frame(input int sb, input logic [7:0] d, input logic [2:0] s, input bit hold);
    tx_dat      = d;
    baud_tx_sel = s;
    tx_valid    = 1'b1;
    check("ready_before_accept", (sb == 2) ? rdy2 : rdy1, 1'b1);
    step();
    if (!hold) tx_valid = 1'b0;
  endtask

  // Checks the line cycle by cycle; returns in the first IDLE cycle.
  task automatic check_frame(input int sb, input logic [7:0] d, input int n, input int len);
    bit bad = 0;
    logic t, dn, bs, rd;
    logic ev;
    for (int c = 0; c < len; c++) begin
      t  = (sb == 2) ? tx2   : tx1;
      dn = (sb == 2) ? done2 : done1;
      bs = (sb == 2) ? busy2 : busy1;
      rd = (sb == 2) ? rdy2  : rdy1;
      ev = exp_line(c / n, d);
      if (t !== ev || dn !== 1'b0 || bs !== 1'b1 || rd !== 1'b0) bad = 1;
      if ((c % n) == n - 1) begin
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame_bit %0d of byte %0h: tx=%b done=%b busy=%b ready=%b at cycle %0d, expected tx=%b done=0 busy=1 ready=0",
                   c / n, d, t, dn, bs, rd, c, ev);
        end
        bad = 0;
      end
      step();
    end
    t  = (sb == 2) ? tx2   : tx1;
    dn = (sb == 2) ? done2 : done1;
    bs = (sb == 2) ? busy2 : busy1;
    check("frame_end_done", dn, 1'b1);
    check("frame_end_line", {bs, t}, 2'b01);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 3'd7, 1, 108, 1080 + PAR * 108};
    vecs[1] = '{8'h3C, 3'd7, 1, 108, 1080 + PAR * 108};
    vecs[2] = '{8'h07, 3'd6, 1, 217, 2170 + PAR * 217};
    vecs[3] = '{8'h03, 3'd7, 2, 108, 1188 + PAR * 108};
    vecs[4] = '{8'h55, 3'd7, 2, 108, 1188 + PAR * 108};
    vecs[5] = '{8'h81, 3'd5, 1, 434, 4340 + PAR * 434};

    resetn = 1'b0; en1 = 1'b0; en2 = 1'b0;
    baud_tx_sel = 3'd7; tx_valid = 1'b0; tx_dat = 8'h00;
    repeat (3) step();
    check("reset_tx", {tx1, tx2}, 2'b11);
    check("reset_busy_done", {busy1, busy2, done1, done2}, 4'b0000);
    check("reset_ready_dis", rdy1, 1'b0);
    en1 = 1'b1;
    #1;
    check("reset_ready_en", rdy1, 1'b1);
    step();
    resetn = 1'b1;
    step();

    // Table of single frames on either instance.
    for (int v = 0; v < 6; v++) begin
      en1 = (vecs[v].sb == 1);
      en2 = (vecs[v].sb == 2);
      step();
      start_frame(vecs[v].sb, vecs[v].dat, vecs[v].sel, 1'b0);
      check_frame(vecs[v].sb, vecs[v].dat, vecs[v].n, vecs[v].len);
      step();
      check("done_one_cycle", (vecs[v].sb == 2) ? done2 : done1, 1'b0);
    end

    // Back-to-back with tx_valid held; tx_dat change while busy is ignored.
    en1 = 1'b1; en2 = 1'b0;
    step();
    start_frame(1, 8'h00, 3'd7, 1'b1);
    tx_dat = 8'hFF;
    check_frame(1, 8'h00, 108, 1080 + PAR * 108);
    check("b2b_idle_ready", rdy1, 1'b1);
    step();
    check("b2b_restart_low", {busy1, tx1}, 2'b10);
    check_frame(1, 8'hFF, 108, 1080 + PAR * 108);
    tx_valid = 1'b0;
    step();

    // Enable dropped at cycle 500 of a frame.
    start_frame(1, 8'hA5, 3'd7, 1'b0);
    repeat (500) step();
    check("abort_line_before", tx1, 1'b0);
    en1 = 1'b0;
    step();
    check("abort_line_idle", {busy1, tx1, done1}, 3'b010);
    begin
      bit seen = 0;
      for (int c = 0; c < 1200; c++) begin
        if (done1 !== 1'b0 || tx1 !== 1'b1) seen = 1;
        step();
      end
      check("abort_no_done", seen, 1'b0);
    end
    en1 = 1'b1;
    step();
    start_frame(1, 8'h3C, 3'd7, 1'b0);
    check_frame(1, 8'h3C, 108, 1080 + PAR * 108);
    step();

    // Baud select changed mid-frame only affects the next frame.
    start_frame(1, 8'hA5, 3'd7, 1'b0);
    baud_tx_sel = 3'd0;
    check_frame(1, 8'hA5, 108, 1080 + PAR * 108);
    step();
    start_frame(1, 8'h01, 3'd0, 1'b0);
    begin
      bit bad = 0;
      for (int c = 0; c < 10416; c++) begin
        if (tx1 !== 1'b0) bad = 1;
        step();
      end
      check("slow_start_low", bad, 1'b0);
    end
    check("slow_bit0_high", tx1, 1'b1);
    en1 = 1'b0;
    step();
    check("slow_abort", {busy1, tx1}, 2'b01);

    // Asynchronous reset in the middle of DATA on the 2-stop-bit instance.
    en2 = 1'b1;
    step();
    start_frame(2, 8'h55, 3'd7, 1'b0);
    repeat (300) step();
    check("rst_line_before", tx2, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst_line_async", {busy2, tx2}, 2'b01);
    step();
    resetn = 1'b1;
    begin
      bit seen = 0;
      for (int c = 0; c < 1300; c++) begin
        if (done2 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) seen = 1;
        step();
      end
      check("rst_no_completion", seen, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
